clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 64 ++++++
 rtl/clk_div_multi.sv | 119 +++++++++++
 3 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_multi_pkg;

  typedef enum logic [0:0] {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } lock_state_e;

  function automatic int ch_width(input int num_ch);
    int w;
    if (num_ch > 1) begin
      w = $clog2(num_ch);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: wrapping phase counter plus registered square-wave and tick decode.
module clk_div_chan #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] load_phase,
  output logic             outclk,
  output logic             tick
);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_next_s;
  logic             wrap_s;
  logic             high_s;
  logic             outclk_r;
  logic             tick_r;

  // Terminal-count and high-half decode; a load overrides counting regardless of enable.
  always_comb begin
    wrap_s     = (cnt_r == (div_r - DIV_W'(1)));
    high_s     = (cnt_r < (div_r >> 1));
    cnt_next_s = cnt_r;
    if (load) begin
      cnt_next_s = load_phase;
    end else if (en) begin
      if (wrap_s) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_r + DIV_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r    <= DIV_W'(DEF_DIV);
      cnt_r    <= '0;
      outclk_r <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      if (load) begin
        div_r <= load_div;
      end else begin
        div_r <= div_r;
      end
      cnt_r    <= cnt_next_s;
      outclk_r <= en & high_s;
      tick_r   <= en & wrap_s;
    end
  end

  assign outclk = outclk_r;
  assign tick   = tick_r;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: configuration validation, per-channel dividers and a lock FSM
// that reports when no valid reconfiguration has happened for LOCK_CYCLES cycles.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [DIV_W-1:0]              cfg_phase,
  output logic                          cfg_err,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             outclk,
  output logic [NUM_CH-1:0]             tick,
  output logic                          locked
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  lock_state_e     state_r;
  lock_state_e     state_next_s;
  logic [LC_W-1:0] lock_cnt_r;
  logic [LC_W-1:0] lock_cnt_next_s;
  logic            locked_r;
  logic            ready_r;
  logic            err_r;
  logic [CH_W:0]   ch_ext_s;
  logic            cfg_ok_s;
  logic            accept_s;
  logic            good_s;
  logic            bad_s;
  logic            term_s;

  // Handshake and validation; the channel index is widened so out-of-range values are visible.
  always_comb begin
    ch_ext_s = {1'b0, cfg_ch};
    cfg_ok_s = (cfg_div >= DIV_W'(2)) && (cfg_phase < cfg_div) &&
               (ch_ext_s < (CH_W+1)'(NUM_CH));
    accept_s = cfg_valid & ready_r;
    good_s   = accept_s & cfg_ok_s;
    bad_s    = accept_s & ~cfg_ok_s;
    term_s   = (lock_cnt_r == LC_W'(LOCK_CYCLES - 1));
  end

  // Lock FSM next state; a valid reconfiguration beats the terminal count.
  always_comb begin
    state_next_s    = state_r;
    lock_cnt_next_s = lock_cnt_r;
    case (state_r)
      LOCKING: begin
        if (good_s) begin
          lock_cnt_next_s = '0;
        end else if (term_s) begin
          state_next_s = LOCKED;
        end else begin
          lock_cnt_next_s = lock_cnt_r + LC_W'(1);
        end
      end
      LOCKED: begin
        if (good_s) begin
          state_next_s    = LOCKING;
          lock_cnt_next_s = '0;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: begin
        state_next_s    = LOCKING;
        lock_cnt_next_s = '0;
      end
    endcase
  end

  // Lock FSM, handshake and error registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r    <= LOCKING;
      lock_cnt_r <= '0;
      locked_r   <= 1'b0;
      ready_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      lock_cnt_r <= lock_cnt_next_s;
      locked_r   <= (state_next_s == LOCKED);
      ready_r    <= 1'b1;
      err_r      <= bad_s;
    end
  end

  assign cfg_ready = ready_r;
  assign cfg_err   = err_r;
  assign locked    = locked_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk        (refclk),
      .rst        (rst),
      .en         (ch_en[i]),
      .load       (good_s && (ch_ext_s == (CH_W+1)'(i))),
      .load_div   (cfg_div),
      .load_phase (cfg_phase),
      .outclk     (outclk[i]),
      .tick       (tick[i])
    );
  end

endmodule
